// File: rtl/npu_host_pkg.sv
// npu_host_pkg -- shared types and constants for the NPU host sequencer.
//   state_t            : sequencer FSM states
//   SEL_*              : NPU address region selects (addra[14:12])
//   CTRL_*_BIT         : bit positions inside a control-register write
//   IDX_* / STAT_IDX_* : fixed word indices for control and status accesses
//   npu_addr()         : builds a 16-bit NPU address from sel and idx
package npu_host_pkg;

  typedef enum logic [4:0] {
    IDLE,
    LD_IMG,
    LD_WC,
    LD_FC2,
    TRIG1,
    RUN1,
    NEXT1,
    TRIG2,
    RUN2,
    NEXT2,
    FC_W,
    FC_GO,
    FC_NXT,
    POLL,
    POLL_WAIT,
    RD_RES,
    RD_WAIT,
    FIN
  } state_t;

  localparam logic [2:0] SEL_IMG  = 3'd1;
  localparam logic [2:0] SEL_WC   = 3'd2;
  localparam logic [2:0] SEL_FC1  = 3'd3;
  localparam logic [2:0] SEL_FC2  = 3'd4;
  localparam logic [2:0] SEL_CTRL = 3'd5;
  localparam logic [2:0] SEL_STAT = 3'd6;

  localparam int CTRL_TRIGGER_BIT    = 0;
  localparam int CTRL_SAVE_DONE_BIT  = 2;
  localparam int CTRL_NEXT_LAYER_BIT = 3;

  localparam logic [31:0] CTRL_TRIGGER    = 32'(1) << CTRL_TRIGGER_BIT;
  localparam logic [31:0] CTRL_SAVE_DONE  = 32'(1) << CTRL_SAVE_DONE_BIT;
  localparam logic [31:0] CTRL_NEXT_LAYER = 32'(1) << CTRL_NEXT_LAYER_BIT;

  localparam logic [11:0] IDX_CTRL         = 12'd0;
  localparam logic [11:0] IDX_START_SINGLE = 12'd2;
  localparam logic [11:0] IDX_FC1_NEXT     = 12'd3;
  localparam logic [11:0] STAT_IDX_DONE    = 12'd0;
  localparam logic [11:0] STAT_IDX_RESULT  = 12'd4;

  // Bit 15 of the NPU address space is never used by the host.
  function automatic logic [15:0] npu_addr(input logic [2:0] sel, input logic [11:0] idx);
    return {1'b0, sel, idx};
  endfunction

endpackage

// File: rtl/npu_host_if.sv
// npu_host_if -- upstream word stream plus NPU single-port bus.
//   in_valid/in_ready/in_data : word stream feeding the sequencer
//   ena/wea/addra/dina        : NPU port request (driven by the sequencer)
//   douta                     : NPU read data, valid one cycle after a read
// modport master : the sequencer side; modport slave : stream source + NPU side.
interface npu_host_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        ena;
  logic        wea;
  logic [15:0] addra;
  logic [31:0] dina;
  logic [31:0] douta;

  modport master (
    input  in_valid, in_data, douta,
    output in_ready, ena, wea, addra, dina
  );

  modport slave (
    output in_valid, in_data, douta,
    input  in_ready, ena, wea, addra, dina
  );
endinterface

// File: rtl/npu_host_timer.sv
// npu_host_timer -- loadable down-counter used for the fixed conv waits.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load count with load_val this cycle
//   load_val  : reload value
//   expired   : count has reached zero
module npu_host_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/npu_host_seq.sv
// npu_host_seq -- host-side job sequencer for a small NPU.
// Streams image / conv kernel / fc2 weights into the NPU, runs both conv
// layers, streams fc1 weight groups one at a time, polls for completion and
// reads back the signed 24-bit logit.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle job start (ignored while busy)
//   bus (master)    : word stream in + NPU port out (all NPU outputs registered)
//   busy            : high in every state except IDLE
//   done            : one-cycle completion pulse
//   error           : sticky poll-timeout flag
//   result          : logit of the last completed job
// Optional build macro NPU_HOST_TIMEOUT_EN bounds status polling to POLL_MAX
// polls; without it polling is unbounded and error is tied low.
module npu_host_seq
  import npu_host_pkg::*;
#(
  parameter int IMG_WORDS  = 60,
  parameter int WC_WORDS   = 3,
  parameter int FC2_WORDS  = 3,
  parameter int FC1_GROUPS = 330,
  parameter int CONV_WAIT  = 200,
  parameter int POLL_MAX   = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  npu_host_if.master  bus,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [23:0] result
);

  localparam int TW = $clog2(CONV_WAIT + 2);
  localparam int GW = (FC1_GROUPS < 2) ? 1 : $clog2(FC1_GROUPS);

  localparam logic [11:0]   IMG_LAST = 12'(IMG_WORDS - 1);
  localparam logic [11:0]   WC_LAST  = 12'(WC_WORDS - 1);
  localparam logic [11:0]   FC2_LAST = 12'(FC2_WORDS - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(FC1_GROUPS - 1);

  state_t        state_q, state_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [23:0]   result_q, result_d;
  logic          rd_valid_q;
  logic          ena_q, ena_d, wea_q, wea_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic          timer_load, timer_expired;
  logic          accept;
  logic          douta_unused;

`ifdef NPU_HOST_TIMEOUT_EN
  localparam int           PW        = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  logic [PW-1:0] poll_q, poll_d;
  logic          error_q, error_d;
`else
  localparam int poll_max_unused = POLL_MAX;
`endif

  npu_host_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (TW'(CONV_WAIT)),
    .expired  (timer_expired)
  );

  assign bus.in_ready = (state_q inside {LD_IMG, LD_WC, LD_FC2, FC_W});
  assign accept       = bus.in_ready & bus.in_valid;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);
  assign result       = result_q;
  assign douta_unused = ^bus.douta[31:24];

  assign bus.ena   = ena_q;
  assign bus.wea   = wea_q;
  assign bus.addra = addr_q;
  assign bus.dina  = din_q;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grp_d      = grp_q;
    result_d   = result_q;
    ena_d      = 1'b0;
    wea_d      = 1'b0;
    addr_d     = '0;
    din_d      = '0;
    timer_load = 1'b0;
`ifdef NPU_HOST_TIMEOUT_EN
    poll_d     = poll_q;
    error_d    = error_q;
`endif

    case (state_q)
      IDLE: if (start) begin
        state_d = LD_IMG;
        cnt_d   = '0;
        grp_d   = '0;
`ifdef NPU_HOST_TIMEOUT_EN
        poll_d  = '0;
        error_d = 1'b0;
`endif
      end

      // Each accepted word becomes one registered write on the next cycle.
      LD_IMG: if (accept) begin
        {ena_d, wea_d, addr_d, din_d} = {2'b11, npu_addr(SEL_IMG, cnt_q), bus.in_data};
        cnt_d = (cnt_q == IMG_LAST) ? 12'd0 : cnt_q + 12'd1;
        if (cnt_q == IMG_LAST) state_d = LD_WC;
      end

      LD_WC: if (accept) begin
        {ena_d, wea_d, addr_d, din_d} = {2'b11, npu_addr(SEL_WC, cnt_q), bus.in_data};
        cnt_d = (cnt_q == WC_LAST) ? 12'd0 : cnt_q + 12'd1;
        if (cnt_q == WC_LAST) state_d = LD_FC2;
      end

      LD_FC2: if (accept) begin
        {ena_d, wea_d, addr_d, din_d} = {2'b11, npu_addr(SEL_FC2, cnt_q), bus.in_data};
        cnt_d = (cnt_q == FC2_LAST) ? 12'd0 : cnt_q + 12'd1;
        if (cnt_q == FC2_LAST) state_d = TRIG1;
      end

      // The timer is loaded alongside the trigger; RUN sits idle until it
      // drains, giving exactly CONV_WAIT empty port cycles before save_done.
      TRIG1, TRIG2: begin
        {ena_d, wea_d, addr_d, din_d} = {2'b11, npu_addr(SEL_CTRL, IDX_CTRL), CTRL_TRIGGER};
        timer_load = 1'b1;
        state_d    = (state_q == TRIG1) ? RUN1 : RUN2;
      end

      RUN1, RUN2: if (timer_expired) begin
        {ena_d, wea_d, addr_d, din_d} = {2'b11, npu_addr(SEL_CTRL, IDX_CTRL), CTRL_SAVE_DONE};
        state_d = (state_q == RUN1) ? NEXT1 : NEXT2;
      end

      NEXT1, NEXT2: begin
        {ena_d, wea_d, addr_d, din_d} = {2'b11, npu_addr(SEL_CTRL, IDX_CTRL), CTRL_NEXT_LAYER};
        state_d = (state_q == NEXT1) ? TRIG2 : FC_W;
      end

      FC_W: if (accept) begin
        {ena_d, wea_d, addr_d, din_d} = {2'b11, npu_addr(SEL_FC1, 12'd0), bus.in_data};
        state_d = FC_GO;
      end

      FC_GO: begin
        {ena_d, wea_d, addr_d, din_d} = {2'b11, npu_addr(SEL_CTRL, IDX_START_SINGLE), CTRL_TRIGGER};
        state_d = FC_NXT;
      end

      FC_NXT: begin
        {ena_d, wea_d, addr_d, din_d} = {2'b11, npu_addr(SEL_CTRL, IDX_FC1_NEXT), CTRL_TRIGGER};
        grp_d   = (grp_q == GRP_LAST) ? '0 : grp_q + 1'b1;
        state_d = (grp_q == GRP_LAST) ? POLL : FC_W;
      end

      POLL: begin
        {ena_d, wea_d, addr_d} = {2'b10, npu_addr(SEL_STAT, STAT_IDX_DONE)};
        state_d = POLL_WAIT;
      end

      // rd_valid_q marks the cycle in which douta carries the read issued two
      // cycles earlier (request register + NPU read latency).
      POLL_WAIT: if (rd_valid_q) begin
        if (bus.douta[0]) begin
          state_d = RD_RES;
        end else begin
`ifdef NPU_HOST_TIMEOUT_EN
          if (poll_q == POLL_LAST) begin
            error_d = 1'b1;
            state_d = FIN;
          end else begin
            poll_d  = poll_q + 1'b1;
            state_d = POLL;
          end
`else
          state_d = POLL;
`endif
        end
      end

      RD_RES: begin
        {ena_d, wea_d, addr_d} = {2'b10, npu_addr(SEL_STAT, STAT_IDX_RESULT)};
        state_d = RD_WAIT;
      end

      RD_WAIT: if (rd_valid_q) begin
        result_d = bus.douta[23:0];
        state_d  = FIN;
      end

      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      grp_q      <= '0;
      result_q   <= '0;
      rd_valid_q <= 1'b0;
      ena_q      <= 1'b0;
      wea_q      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grp_q      <= grp_d;
      result_q   <= result_d;
      rd_valid_q <= ena_q & ~wea_q;
      ena_q      <= ena_d;
      wea_q      <= wea_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

`ifdef NPU_HOST_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_q  <= '0;
      error_q <= 1'b0;
    end else begin
      poll_q  <= poll_d;
      error_q <= error_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_npu_host_seq.sv
// tb_npu_host_seq -- scoreboard bench for npu_host_seq.
// Expected NPU port transactions are queued as stimulus is driven and popped
// by a negedge monitor; a behavioural NPU answers status/result reads.
// Timeout scenario runs only when NPU_HOST_TIMEOUT_EN is defined.
module tb_npu_host_seq;
  import npu_host_pkg::*;

  localparam int IMG_WORDS  = 60;
  localparam int WC_WORDS   = 3;
  localparam int FC2_WORDS  = 3;
  localparam int FC1_GROUPS = 2;
  localparam int CONV_WAIT  = 200;
  localparam int POLL_MAX   = 4;

  typedef struct {
    logic        wea;
    logic [15:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, error;
  logic [23:0] result;

  npu_host_if bus ();

  npu_host_seq #(
    .IMG_WORDS (IMG_WORDS), .WC_WORDS (WC_WORDS), .FC2_WORDS (FC2_WORDS),
    .FC1_GROUPS(FC1_GROUPS), .CONV_WAIT(CONV_WAIT), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (bus.master),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .result (result)
  );

  always #5 clk = ~clk;

  txn_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          cyc      = 0;
  int          t_trig   = 0;
  bit          prev_done = 1'b0;
  bit          abort     = 1'b0;
  int          done_at   = 3;
  logic [31:0] result_word = 32'h00FF_FF85;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void exp_push(input logic wea, input logic [2:0] sel,
                                   input logic [11:0] idx, input logic [31:0] data);
    txn_t t;
    t.wea  = wea;
    t.addr = {1'b0, sel, idx};
    t.data = data;
    exp_q.push_back(t);
  endfunction

  // Behavioural NPU: synchronous read port, done bit set from the done_at-th poll.
  initial begin
    int poll_n = 0;
    bus.douta = '0;
    forever begin
      @(posedge clk);
      if (start) poll_n = 0;
      if (bus.ena && !bus.wea) begin
        if (bus.addra == 16'h6000) begin
          poll_n++;
          bus.douta <= (poll_n >= done_at) ? 32'h1 : 32'h0;
        end else if (bus.addra == 16'h6004) begin
          bus.douta <= result_word;
        end else begin
          bus.douta <= 32'hDEAD_0000;
        end
      end
    end
  end

  // Port monitor and scoreboard.
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          check("done_single_pulse", done, 0);
          check("busy_after_done", busy, 0);
        end
        if (done) begin
          done_cnt++;
          check("busy_with_done", busy, 1);
        end
        prev_done = done;
        if (bus.ena) begin
          if (exp_q.size() == 0) begin
            check("txn_underflow", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("txn_wea", bus.wea, e.wea);
            check("txn_addra", bus.addra, e.addr);
            if (e.wea) check("txn_dina", bus.dina, e.data);
          end
          if (bus.wea && bus.addra == 16'h5000) begin
            if (bus.dina == 32'h1) t_trig = cyc;
            else if (bus.dina == 32'h4) check("conv_gap", cyc - t_trig - 1, CONV_WAIT);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents one word (optionally after an idle cycle) and returns once accepted.
  task automatic send_word(input logic [31:0] w, input bit gap);
    if (abort) return;
    if (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int k = 0; k < 2000; k++) begin
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("in_ready_timeout", bus.in_ready, 1);
    abort = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    if (abort) return;
    for (int k = 0; k < budget; k++) begin
      if (done) return;
      @(posedge clk); #1;
    end
    check("done_timeout", done, 1);
    abort = 1'b1;
  endtask

  task automatic stream_loads(input bit gap_img, input int n_fc2);
    logic [31:0] w;
    for (int i = 0; i < IMG_WORDS; i++) begin
      w = $urandom;
      send_word(w, gap_img);
      if (!abort) exp_push(1'b1, 3'd1, 12'(i), w);
    end
    for (int i = 0; i < WC_WORDS; i++) begin
      w = $urandom;
      send_word(w, 1'b0);
      if (!abort) exp_push(1'b1, 3'd2, 12'(i), w);
    end
    for (int i = 0; i < n_fc2; i++) begin
      w = $urandom;
      send_word(w, 1'b0);
      if (!abort) exp_push(1'b1, 3'd4, 12'(i), w);
    end
  endtask

  task automatic run_job(input int npoll, input bit with_result);
    logic [31:0] w;
    int snap;
    snap = done_cnt;
    pulse_start();
    stream_loads(1'b1, FC2_WORDS);
    for (int l = 0; l < 2; l++) begin
      exp_push(1'b1, 3'd5, 12'd0, 32'h1);
      exp_push(1'b1, 3'd5, 12'd0, 32'h4);
      exp_push(1'b1, 3'd5, 12'd0, 32'h8);
    end
    for (int g = 0; g < FC1_GROUPS; g++) begin
      w = $urandom;
      send_word(w, 1'b0);
      if (!abort) begin
        exp_push(1'b1, 3'd3, 12'd0, w);
        exp_push(1'b1, 3'd5, 12'd2, 32'h1);
        exp_push(1'b1, 3'd5, 12'd3, 32'h1);
      end
    end
    for (int p = 0; p < npoll; p++) exp_push(1'b0, 3'd6, 12'd0, 32'h0);
    if (with_result) exp_push(1'b0, 3'd6, 12'd4, 32'h0);
    wait_done(2000);
    repeat (3) begin @(posedge clk); #1; end
    check("done_pulse_count", done_cnt - snap, 1);
    check("queue_drained", exp_q.size(), 0);
    check("busy_after_job", busy, 0);
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_ena"},      bus.ena, 0);
    check({pfx, "_wea"},      bus.wea, 0);
    check({pfx, "_addra"},    bus.addra, 0);
    check({pfx, "_dina"},     bus.dina, 0);
    check({pfx, "_in_ready"}, bus.in_ready, 0);
    check({pfx, "_busy"},     busy, 0);
    check({pfx, "_done"},     done, 0);
    check({pfx, "_error"},    error, 0);
    check({pfx, "_result"},   result, 0);
  endtask

  initial begin
    logic [31:0] w;
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full job: done on third poll, negative logit.
    done_at     = 3;
    result_word = 32'h00FF_FF85;
    run_job(3, 1'b1);
    check("result_negative", result, 24'hFFFF85);
    check("error_after_job", error, 0);

`ifdef NPU_HOST_TIMEOUT_EN
    // Done never set: POLL_MAX polls, error, done pulse, result unchanged.
    done_at = 1000;
    run_job(POLL_MAX, 1'b0);
    check("timeout_error", error, 1);
    check("timeout_result_kept", result, 24'hFFFF85);
    pulse_start();
    check("error_cleared_by_start", error, 0);
`else
    pulse_start();
`endif

    // Reset in the middle of LD_FC2.
    stream_loads(1'b0, 1);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_reset_drained", exp_q.size(), 0);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_in_ready", bus.in_ready, 1);
    #2;
    rst = 1'b1;
    #1;
    check_idle("midjob_reset");
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // New job restarts at image word 0.
    pulse_start();
    w = 32'hCAFE_F00D;
    send_word(w, 1'b0);
    if (!abort) exp_push(1'b1, 3'd1, 12'd0, w);
    repeat (2) begin @(posedge clk); #1; end
    check("restart_img_word0", exp_q.size(), 0);
    check("restart_busy", busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/npu_host_seq.md
NPU_HOST_SEQ -- requirements
Module: npu_host_seq

Interface
REQ-001 SHALL have parameter IMG_WORDS, default 60: image words written, 4 pixels per word (16x15 image).
REQ-002 SHALL have parameter WC_WORDS, default 3: conv-kernel words (9 bytes).
REQ-003 SHALL have parameter FC2_WORDS, default 3: fc2 weight words (10 bytes).
REQ-004 SHALL have parameter FC1_GROUPS, default 330: fc1 4-weight groups streamed.
REQ-005 SHALL have parameter CONV_WAIT, default 200: cycles waited after each conv trigger.
REQ-006 SHALL have parameter POLL_MAX, default 4095: maximum done polls before error.
REQ-007 clk  input  1  clock.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 start  input  1  one-cycle job start pulse.
REQ-010 in_valid / in_ready / in_data  input / output / input  1/1/32  upstream word stream: image, kernel, fc2, then fc1 groups, in that order.
REQ-011 ena / wea  output  1/1  NPU port enable and write.
REQ-012 addra  output  16  NPU address; [14:12] sel, [11:0] idx, [15] always 0.
REQ-013 dina  output  32  NPU write data.
REQ-014 douta  input  32  NPU read data, valid 1 cycle after a read (ena=1, wea=0).
REQ-015 busy / done / error  output  1/1/1  job active; one-cycle completion pulse; sticky timeout flag.
REQ-016 result  output  24  signed logit from the last completed job.

Function
REQ-017 SHALL register all NPU port outputs; one port access per cycle at most; ena=0 when idle.
REQ-018 SHALL use sel 1 image, 2 kernel, 3 fc1 group, 4 fc2, 5 control write, 6 status read; idx = word index within its region.
REQ-019 Control writes (sel 5) SHALL encode dina bit0 trigger, bit2 save_done, bit3 next_layer; idx 2 = start_single, idx 3 = fc1_next.
REQ-020 States SHALL be IDLE, LD_IMG, LD_WC, LD_FC2, TRIG1, RUN1, NEXT1, TRIG2, RUN2, NEXT2, FC_W, FC_GO, FC_NXT, POLL, POLL_WAIT, RD_RES, RD_WAIT, FIN.
REQ-021 IDLE->LD_IMG on start; start while busy SHALL be ignored.
REQ-022 in_ready SHALL be 1 only in LD_IMG, LD_WC, LD_FC2, FC_W; each accepted word SHALL become exactly one NPU write on the next cycle, with idx = word counter.
REQ-023 Load states SHALL advance when counter reaches IMG_WORDS-1 / WC_WORDS-1 / FC2_WORDS-1 on an accepted word; counter resets per region.
REQ-024 TRIG1 SHALL write sel5 dina=0x1; RUN1 SHALL wait CONV_WAIT cycles, then write save_done (0x4); NEXT1 SHALL write next_layer (0x8); TRIG2/RUN2/NEXT2 SHALL repeat the sequence for conv2.
REQ-025 For each fc1 group, the block SHALL perform FC_W (accept word, write sel3 idx0), then FC_GO (sel5 idx2), then FC_NXT (sel5 idx3), in that order; after group FC1_GROUPS-1 it SHALL go to POLL.
REQ-026 POLL SHALL issue a sel6 idx0 read; POLL_WAIT SHALL sample douta[0]: 1 -> RD_RES, 0 -> POLL.
REQ-027 RD_RES SHALL issue a sel6 idx4 read; RD_WAIT SHALL latch result=douta[23:0]; FIN SHALL pulse done for 1 cycle, then return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 in_valid low SHALL stall the FSM in load and FC_W states with ena=0; no timeout SHALL apply to stalls.

Reset
REQ-030 rst SHALL force IDLE, all counters 0, ena=wea=0, addra=dina=0, in_ready=0, busy=done=error=0, result=0, including during a job; no partial transaction SHALL be completed.

Configuration
REQ-031 With NPU_HOST_TIMEOUT_EN defined, a poll counter SHALL increment per POLL_WAIT with done=0; reaching POLL_MAX SHALL set error, pulse done and return to IDLE with result unchanged; error SHALL clear on the next accepted start.
REQ-032 Without NPU_HOST_TIMEOUT_EN, polling SHALL be unbounded and error SHALL be tied 0.

Structure
REQ-033 Package npu_host_pkg SHALL hold the state enum, sel constants (SEL_IMG..SEL_STAT), control bit positions, and status idx constants.
REQ-034 A single sub-module npu_host_timer (loadable down-counter with expiry flag) SHALL implement CONV_WAIT waits.

Verification
REQ-035 Full job with the NPU model returning done at poll 3 and douta=0x00FFFF85 -> result=0xFFFF85 (negative), single done pulse, busy falls with done.
REQ-036 Image load: 60 words streamed with in_valid toggling every other cycle -> 60 sel1 writes, idx 0..59, data matching, no gaps other than stalls.
REQ-037 Conv sequence: control writes are 0x1, 0x4 after exactly 200 idle cycles, then 0x8, twice, in that order.
REQ-038 FC stream, FC1_GROUPS=2 -> writes sel3, sel5/idx2, sel5/idx3, repeated twice, then a sel6 idx0 read.
REQ-039 With NPU_HOST_TIMEOUT_EN, POLL_MAX=4 and done never set -> error=1 after 4 polls, done pulse; a new start clears error.
REQ-040 rst asserted mid LD_FC2 -> all outputs 0 immediately; a new start reloads from image word 0.
